drp_reconf_master: RTL and testbench
====================================

Name: drp_reconf_master

Overview:
DRP initiator that drives the PLL's dynamic reconfiguration port (DADDR/DEN/DWE/DI in, DO/DRDY back). On request it holds the PLL in reset. It then runs a read-modify-write on every entry of one of two stored configuration sets, releases the PLL reset and waits for LOCKED. It sits between system control logic and the PLL's DRP and replaces hand-driven DRP sequences in benches and designs.

Parameters:
NUM_ENTRIES, 23, entries per configuration set (one per PLL DRP register)
DRDY_TIMEOUT, 64, DCLK cycles allowed between DEN and DRDY
LOCK_TIMEOUT, 65535, DCLK cycles allowed for LOCKED after PLL_RST release
IDX_W, $clog2(NUM_ENTRIES), table index width

Ports:
DCLK  in  1  single clock for all logic
RST_N  in  1  synchronous reset, active-low
SEN  in  1  start pulse, sampled only in IDLE
SSEL  in  1  configuration set to apply, captured with SEN
SRDY  out  1  one-cycle pulse: sequence finished (ok or error)
BUSY  out  1  high from SEN acceptance until the SRDY cycle inclusive
ERR  out  1  sticky error flag, cleared on the next accepted SEN
CFG_WE  in  1  table write strobe
CFG_SEL  in  1  set selected for table write
CFG_IDX  in  IDX_W  entry index for table write
CFG_ADDR  in  7  DRP address for entry
CFG_MASK  in  16  bits set to 1 keep the read-back value
CFG_DATA  in  16  new value for bits where mask is 0
DADDR  out  7  DRP address
DEN  out  1  DRP enable, exactly one cycle per transaction
DWE  out  1  DRP write enable, valid only with DEN
DI  out  16  DRP write data
DO  in  16  DRP read data, valid with DRDY
DRDY  in  1  DRP transaction complete
LOCKED  in  1  PLL lock indicator
PLL_RST  out  1  PLL reset, held during reconfiguration

Behaviour:
- Reset (RST_N=0 at DCLK edge): state IDLE. DEN, DWE, SRDY, BUSY, ERR and PLL_RST are 0; DADDR and DI are 0; entry counter is 0; table contents are preserved.
- Table: 2 x NUM_ENTRIES x 39 bits. CFG_WE writes on the edge. Writes are ignored while BUSY=1 or CFG_IDX>=NUM_ENTRIES.
- States: IDLE -> ASSERT_RST -> RD_REQ -> RD_WAIT -> WR_REQ -> WR_WAIT -> (next entry: RD_REQ | last: WAIT_LOCK) -> DONE -> IDLE. Any timeout goes to FAIL -> IDLE.
- IDLE: on SEN=1, capture SSEL, set BUSY, clear ERR and go to ASSERT_RST. PLL_RST is 1 from the next cycle.
- ASSERT_RST: one cycle, then RD_REQ with entry 0.
- RD_REQ: DEN=1, DWE=0, DADDR=entry address for one cycle, then RD_WAIT.
- RD_WAIT: on DRDY=1, latch merged = (DO & MASK) | (DATA & ~MASK).
- WR_REQ: DEN=1, DWE=1, DADDR held, DI=merged for one cycle.
- WR_WAIT: on DRDY=1, increment entry. Entry NUM_ENTRIES-1 leads to WAIT_LOCK with PLL_RST=0 from the next cycle.
- DEN is never reasserted before DRDY for the pending transaction. A DRDY arriving in the same cycle as DEN is not accepted; acceptance starts the cycle after DEN. DRDY outside the *_WAIT states is ignored.
- Timeouts: the DRDY wait counter starts at DEN. When it reaches DRDY_TIMEOUT -> FAIL. LOCKED low for LOCK_TIMEOUT cycles in WAIT_LOCK -> FAIL.
- LOCKED=1 in WAIT_LOCK -> DONE.
- FAIL: ERR=1 and PLL_RST=0. FAIL and DONE both emit SRDY=1 for one cycle, drop BUSY after that cycle and return to IDLE.
- SEN while BUSY is ignored, with no queueing.
- RST_N low mid-sequence aborts at the next edge to reset values, with PLL_RST=0. A partially written PLL is left as is.
- Minimum latency per entry is 4 cycles plus DRDY delays.

Decomposition:
- Shared package drp_pkg: DRP address constants (CLKOUT0..6 Reg1/Reg2, CLKFB Reg1/Reg2, DIVCLK, LOCK1-3, POWER, FILT1-2) and the entry struct {addr[6:0], mask[15:0], data[15:0]}. The FSM state enum also lives there.
- One sub-module, drp_cfg_table: dual-set entry storage with a synchronous write port and an asynchronous read port.

Test Plan:
1. Set0 entries {0x08, mask 0xF000, data 0x0041}, {0x09, 0xFFC0, 0x0000}; DO returns 0xABCD then 0x1234; SEN, SSEL=0 -> writes DI=0xA041 to 0x08 and DI=0x1200 to 0x09. PLL_RST stays high throughout and BUSY=1 until SRDY, ERR=0.
2. DRDY responder delay of 0, 1 and 10 cycles -> exactly one DEN per transaction, order RD, WR, RD, WR, ... for all NUM_ENTRIES.
3. DRDY never returns -> FAIL after DRDY_TIMEOUT=64 cycles, ERR=1, SRDY pulse, PLL_RST=0; a later SEN clears ERR.
4. SEN pulsed again mid-sequence and CFG_WE while BUSY -> both ignored; table readback after completion is unchanged.
5. RST_N low during RD_WAIT -> next edge DEN=0, PLL_RST=0, BUSY=0; a fresh SEN restarts from entry 0.
6. LOCKED held low, with LOCK_TIMEOUT set to 100 -> ERR=1 after 100 cycles. With LOCKED rising after 20 cycles -> SRDY 1 cycle later, ERR=0.

Source files
------------

// File: rtl/drp_pkg.sv
// Shared definitions for the PLL DRP reconfiguration master: register map,
// configuration entry layout, sequencer states and the read-modify-write merge.
package drp_pkg;

    localparam logic [6:0] DRP_CLKOUT0_REG1 = 7'h08;
    localparam logic [6:0] DRP_CLKOUT0_REG2 = 7'h09;
    localparam logic [6:0] DRP_CLKOUT1_REG1 = 7'h0A;
    localparam logic [6:0] DRP_CLKOUT1_REG2 = 7'h0B;
    localparam logic [6:0] DRP_CLKOUT2_REG1 = 7'h0C;
    localparam logic [6:0] DRP_CLKOUT2_REG2 = 7'h0D;
    localparam logic [6:0] DRP_CLKOUT3_REG1 = 7'h0E;
    localparam logic [6:0] DRP_CLKOUT3_REG2 = 7'h0F;
    localparam logic [6:0] DRP_CLKOUT4_REG1 = 7'h10;
    localparam logic [6:0] DRP_CLKOUT4_REG2 = 7'h11;
    localparam logic [6:0] DRP_CLKOUT5_REG1 = 7'h06;
    localparam logic [6:0] DRP_CLKOUT5_REG2 = 7'h07;
    localparam logic [6:0] DRP_CLKOUT6_REG1 = 7'h12;
    localparam logic [6:0] DRP_CLKOUT6_REG2 = 7'h13;
    localparam logic [6:0] DRP_CLKFB_REG1   = 7'h14;
    localparam logic [6:0] DRP_CLKFB_REG2   = 7'h15;
    localparam logic [6:0] DRP_DIVCLK       = 7'h16;
    localparam logic [6:0] DRP_LOCK1        = 7'h18;
    localparam logic [6:0] DRP_LOCK2        = 7'h19;
    localparam logic [6:0] DRP_LOCK3        = 7'h1A;
    localparam logic [6:0] DRP_POWER        = 7'h28;
    localparam logic [6:0] DRP_FILT1        = 7'h4E;
    localparam logic [6:0] DRP_FILT2        = 7'h4F;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
    } drp_entry_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ASSERT_RST,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_WAIT_LOCK,
        ST_DONE,
        ST_FAIL
    } drp_state_t;

    // Mask bits set to 1 keep the value read back from the PLL.
    function automatic logic [15:0] drp_merge(input logic [15:0] rd_data, input drp_entry_t entry);
        return (rd_data & entry.mask) | (entry.data & ~entry.mask);
    endfunction

endpackage

// File: rtl/drp_cfg_table.sv
// Two configuration sets of DRP entries: synchronous write port, asynchronous
// read port so the sequencer can pick up the next entry in the same cycle.
module drp_cfg_table
    import drp_pkg::*;
#(
    parameter int NUM_ENTRIES = 23,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             wr_sel,
    input  logic [IDX_W-1:0] wr_idx,
    input  drp_entry_t       wr_entry,
    input  logic             rd_sel,
    input  logic [IDX_W-1:0] rd_idx,
    output drp_entry_t       rd_entry
);

    localparam logic [IDX_W:0] N_ENT = (IDX_W + 1)'(NUM_ENTRIES);

    drp_entry_t mem [0:1][0:NUM_ENTRIES-1];

    logic wr_ok;
    logic rd_ok;

    assign wr_ok = ({1'b0, wr_idx} < N_ENT);
    assign rd_ok = ({1'b0, rd_idx} < N_ENT);

    always_ff @(posedge clk) begin
        if (we && wr_ok) begin
            mem[wr_sel][wr_idx] <= wr_entry;
        end
    end

    // Out-of-range indices read as zero rather than aliasing another entry.
    always_comb begin
        rd_entry = '0;
        if (rd_ok) begin
            rd_entry = mem[rd_sel][rd_idx];
        end
    end

endmodule

// File: rtl/drp_reconf_master.sv
// DRP initiator: holds the PLL in reset, read-modify-writes every entry of the
// selected configuration set, releases reset and waits for LOCKED.
module drp_reconf_master
    import drp_pkg::*;
#(
    parameter int NUM_ENTRIES  = 23,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int IDX_W        = $clog2(NUM_ENTRIES)
) (
    input  logic             DCLK,
    input  logic             RST_N,
    input  logic             SEN,
    input  logic             SSEL,
    output logic             SRDY,
    output logic             BUSY,
    output logic             ERR,
    input  logic             CFG_WE,
    input  logic             CFG_SEL,
    input  logic [IDX_W-1:0] CFG_IDX,
    input  logic [6:0]       CFG_ADDR,
    input  logic [15:0]      CFG_MASK,
    input  logic [15:0]      CFG_DATA,
    output logic [6:0]       DADDR,
    output logic             DEN,
    output logic             DWE,
    output logic [15:0]      DI,
    input  logic [15:0]      DO,
    input  logic             DRDY,
    input  logic             LOCKED,
    output logic             PLL_RST
);

    localparam int TMR_W = $clog2(DRDY_TIMEOUT + 1);
    localparam int LK_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRDY_TIMEOUT - 1);
    localparam logic [LK_W-1:0]  LK_LAST  = LK_W'(LOCK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

    drp_state_t       state_q, state_d;
    logic             sel_q, sel_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    drp_entry_t       cur_q, cur_d;
    logic [15:0]      di_q, di_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [LK_W-1:0]  lk_q, lk_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             pll_rst_q, pll_rst_d;
    logic             go_fail;

    drp_entry_t       cfg_entry;
    drp_entry_t       rd_entry;
    logic [IDX_W-1:0] rd_idx;
    logic             cfg_we;

    assign cfg_entry = '{addr: CFG_ADDR, mask: CFG_MASK, data: CFG_DATA};
    assign cfg_we    = CFG_WE & ~busy_q;
    // While waiting for the write to finish, look ahead to the next entry.
    assign rd_idx    = (state_q == ST_WR_WAIT) ? idx_q + IDX_W'(1) : idx_q;

    drp_cfg_table #(
        .NUM_ENTRIES(NUM_ENTRIES),
        .IDX_W      (IDX_W)
    ) u_table (
        .clk     (DCLK),
        .we      (cfg_we),
        .wr_sel  (CFG_SEL),
        .wr_idx  (CFG_IDX),
        .wr_entry(cfg_entry),
        .rd_sel  (sel_q),
        .rd_idx  (rd_idx),
        .rd_entry(rd_entry)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        cur_d     = cur_q;
        di_d      = di_q;
        tmr_d     = tmr_q;
        lk_d      = lk_q;
        busy_d    = busy_q;
        err_d     = err_q;
        pll_rst_d = pll_rst_q;
        go_fail   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (SEN) begin
                    sel_d     = SSEL;
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                    pll_rst_d = 1'b1;
                    idx_d     = '0;
                    state_d   = ST_ASSERT_RST;
                end
            end
            ST_ASSERT_RST: begin
                cur_d   = rd_entry;
                state_d = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                tmr_d   = TMR_W'(1);
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (DRDY) begin
                    di_d    = drp_merge(DO, cur_q);
                    state_d = ST_WR_REQ;
                end else if (tmr_q == TMR_LAST) begin
                    go_fail = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_WR_REQ: begin
                tmr_d   = TMR_W'(1);
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (DRDY) begin
                    if (idx_q == IDX_LAST) begin
                        pll_rst_d = 1'b0;
                        lk_d      = '0;
                        state_d   = ST_WAIT_LOCK;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        cur_d   = rd_entry;
                        state_d = ST_RD_REQ;
                    end
                end else if (tmr_q == TMR_LAST) begin
                    go_fail = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (LOCKED) begin
                    state_d = ST_DONE;
                end else if (lk_q == LK_LAST) begin
                    go_fail = 1'b1;
                end else begin
                    lk_d = lk_q + LK_W'(1);
                end
            end
            ST_DONE, ST_FAIL: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Failure releases the PLL so it is never left stuck in reset.
        if (go_fail) begin
            err_d     = 1'b1;
            pll_rst_d = 1'b0;
            state_d   = ST_FAIL;
        end
    end

    always_ff @(posedge DCLK) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            sel_q     <= 1'b0;
            idx_q     <= '0;
            cur_q     <= '0;
            di_q      <= '0;
            tmr_q     <= '0;
            lk_q      <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            pll_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            cur_q     <= cur_d;
            di_q      <= di_d;
            tmr_q     <= tmr_d;
            lk_q      <= lk_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            pll_rst_q <= pll_rst_d;
        end
    end

    assign DEN     = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
    assign DWE     = (state_q == ST_WR_REQ);
    assign DADDR   = cur_q.addr;
    assign DI      = di_q;
    assign SRDY    = (state_q == ST_DONE) || (state_q == ST_FAIL);
    assign BUSY    = busy_q;
    assign ERR     = err_q;
    assign PLL_RST = pll_rst_q;

endmodule

// File: tb/tb_drp_reconf_master.sv
// Scoreboard bench for drp_reconf_master: a behavioural PLL DRP responder,
// expected-transaction queues filled at SEN time and a decoupled monitor.
module tb_drp_reconf_master;
    import drp_pkg::*;

    localparam int NE      = 23;
    localparam int IDX_W   = 5;
    localparam int DRDY_TO = 64;
    localparam int LOCK_TO = 100;

    logic             DCLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             SEN = 1'b0;
    logic             SSEL = 1'b0;
    logic             SRDY, BUSY, ERR;
    logic             CFG_WE = 1'b0;
    logic             CFG_SEL = 1'b0;
    logic [IDX_W-1:0] CFG_IDX = '0;
    logic [6:0]       CFG_ADDR = '0;
    logic [15:0]      CFG_MASK = '0;
    logic [15:0]      CFG_DATA = '0;
    logic [6:0]       DADDR;
    logic             DEN, DWE;
    logic [15:0]      DI;
    logic [15:0]      DO = 16'hDEAD;
    logic             DRDY = 1'b0;
    logic             LOCKED = 1'b0;
    logic             PLL_RST;

    drp_reconf_master #(
        .NUM_ENTRIES (NE),
        .DRDY_TIMEOUT(DRDY_TO),
        .LOCK_TIMEOUT(LOCK_TO),
        .IDX_W       (IDX_W)
    ) dut (
        .DCLK(DCLK), .RST_N(RST_N), .SEN(SEN), .SSEL(SSEL), .SRDY(SRDY),
        .BUSY(BUSY), .ERR(ERR), .CFG_WE(CFG_WE), .CFG_SEL(CFG_SEL),
        .CFG_IDX(CFG_IDX), .CFG_ADDR(CFG_ADDR), .CFG_MASK(CFG_MASK),
        .CFG_DATA(CFG_DATA), .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI),
        .DO(DO), .DRDY(DRDY), .LOCKED(LOCKED), .PLL_RST(PLL_RST)
    );

    initial forever #5 DCLK = ~DCLK;

    typedef struct packed {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] di;
    } txn_t;

    int checks   = 0;
    int failures = 0;

    txn_t        exp_q[$];
    logic        exp_err_q[$];
    logic [6:0]  t_addr [0:1][0:NE-1];
    logic [15:0] t_mask [0:1][0:NE-1];
    logic [15:0] t_data [0:1][0:NE-1];
    logic [15:0] exp_mem [0:127];
    logic [15:0] pll_mem [0:127];
    logic [6:0]  addr_list [0:NE-1];
    logic [15:0] hand_di [0:1];

    int mute       = 0;
    int resp_delay = 0;
    int lock_delay = 3;
    int resp_pend  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge DCLK);
    endtask

    // srdy_kind: -1 no SRDY expected, 0 clean finish, 1 error finish.
    task automatic push_run(input int s, input bit full, input bit use_hand, input int srdy_kind);
        txn_t        t;
        logic [6:0]  a;
        logic [15:0] m;
        for (int i = 0; i < NE; i++) begin
            a = t_addr[s][i];
            t = '{we: 1'b0, addr: a, di: 16'h0000};
            exp_q.push_back(t);
            if (!full) break;
            m = (exp_mem[a] & t_mask[s][i]) | (t_data[s][i] & ~t_mask[s][i]);
            if (use_hand && i < 2) m = hand_di[i];
            t = '{we: 1'b1, addr: a, di: m};
            exp_q.push_back(t);
            exp_mem[a] = m;
        end
        if (srdy_kind >= 0) exp_err_q.push_back(srdy_kind[0]);
    endtask

    task automatic start(input int s);
        SEN  = 1'b1;
        SSEL = s[0];
        @(negedge DCLK);
        SEN  = 1'b0;
    endtask

    task automatic wait_srdy(input int max, output int n);
        n = 0;
        while (SRDY !== 1'b1 && n < max) begin
            @(negedge DCLK);
            n++;
        end
        chk("srdy_within_bound", SRDY, 1);
    endtask

    task automatic cfg_write(input int s, input int i, input logic [6:0] a,
                             input logic [15:0] m, input logic [15:0] d);
        CFG_WE   = 1'b1;
        CFG_SEL  = s[0];
        CFG_IDX  = IDX_W'(i);
        CFG_ADDR = a;
        CFG_MASK = m;
        CFG_DATA = d;
        @(negedge DCLK);
        CFG_WE   = 1'b0;
    endtask

    // PLL model: DRDY (delay+1) cycles after DEN, DO valid only with DRDY.
    initial begin
        int          cnt;
        logic [6:0]  pa;
        logic        pw;
        logic [15:0] pd;
        int          lk;
        cnt = 0; pa = '0; pw = 1'b0; pd = '0; lk = 0;
        forever begin
            @(negedge DCLK);
            if (DEN === 1'b1) chk("den_while_pending", resp_pend, 0);
            DRDY = 1'b0;
            DO   = 16'hDEAD;
            if (RST_N === 1'b0) resp_pend = 0;
            if (resp_pend != 0) begin
                if (cnt == 0) begin
                    DRDY = 1'b1;
                    if (pw) pll_mem[pa] = pd;
                    else DO = pll_mem[pa];
                    resp_pend = 0;
                end else begin
                    cnt--;
                end
            end
            if (DEN === 1'b1 && resp_pend == 0 && mute == 0) begin
                resp_pend = 1;
                cnt = resp_delay;
                pa = DADDR;
                pw = DWE;
                pd = DI;
            end
            if (PLL_RST !== 1'b0) begin
                lk = 0;
                LOCKED = 1'b0;
            end else if (lock_delay >= 0) begin
                if (lk >= lock_delay) LOCKED = 1'b1;
                else lk++;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT issues DEN or SRDY.
    initial begin
        txn_t t;
        logic e;
        forever begin
            @(negedge DCLK);
            if (DEN === 1'b1) begin
                chk("pll_rst_during_drp", PLL_RST, 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_den", DEN, 0);
                end else begin
                    t = exp_q.pop_front();
                    $display("DRP %s addr=0x%02h di=0x%04h (exp %s 0x%02h 0x%04h)",
                             DWE ? "WR" : "RD", DADDR, DI, t.we ? "WR" : "RD", t.addr, t.di);
                    chk("den_dwe", DWE, t.we);
                    chk("den_addr", DADDR, t.addr);
                    if (t.we) chk("den_di", DI, t.di);
                end
            end
            if (SRDY === 1'b1) begin
                if (exp_err_q.size() == 0) begin
                    chk("unexpected_srdy", SRDY, 0);
                end else begin
                    e = exp_err_q.pop_front();
                    $display("SRDY err=%0d busy=%0d pll_rst=%0d (exp err %0d)", ERR, BUSY, PLL_RST, e);
                    chk("srdy_err", ERR, e);
                    chk("srdy_busy", BUSY, 1);
                    chk("srdy_pll_rst", PLL_RST, 0);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int extra;
        addr_list = '{DRP_CLKOUT0_REG1, DRP_CLKOUT0_REG2, DRP_CLKOUT1_REG1, DRP_CLKOUT1_REG2,
                      DRP_CLKOUT2_REG1, DRP_CLKOUT2_REG2, DRP_CLKOUT3_REG1, DRP_CLKOUT3_REG2,
                      DRP_CLKOUT4_REG1, DRP_CLKOUT4_REG2, DRP_CLKOUT5_REG1, DRP_CLKOUT5_REG2,
                      DRP_CLKOUT6_REG1, DRP_CLKOUT6_REG2, DRP_CLKFB_REG1, DRP_CLKFB_REG2,
                      DRP_DIVCLK, DRP_LOCK1, DRP_LOCK2, DRP_LOCK3, DRP_POWER, DRP_FILT1, DRP_FILT2};
        hand_di[0] = 16'hA041;
        hand_di[1] = 16'h1200;
        for (int a = 0; a < 128; a++) begin
            pll_mem[a] = (16'(a) << 9) ^ 16'h5A5A;
        end
        pll_mem[8] = 16'hABCD;
        pll_mem[9] = 16'h1234;
        exp_mem = pll_mem;
        for (int i = 0; i < NE; i++) begin
            t_addr[0][i] = addr_list[i];
            t_mask[0][i] = 16'hFF00 ^ (16'(i) << 4);
            t_data[0][i] = 16'(i) * 16'h0203;
            t_addr[1][i] = addr_list[NE - 1 - i];
            t_mask[1][i] = 16'h00FF | (16'(i) << 10);
            t_data[1][i] = 16'hC3A0 ^ 16'(i);
        end
        t_addr[0][0] = 7'h08; t_mask[0][0] = 16'hF000; t_data[0][0] = 16'h0041;
        t_addr[0][1] = 7'h09; t_mask[0][1] = 16'hFFC0; t_data[0][1] = 16'h0000;

        // Reset values
        tick(3);
        chk("rst_den", DEN, 0);
        chk("rst_dwe", DWE, 0);
        chk("rst_srdy", SRDY, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_err", ERR, 0);
        chk("rst_pll_rst", PLL_RST, 0);
        chk("rst_daddr", DADDR, 0);
        chk("rst_di", DI, 0);
        RST_N = 1'b1;
        tick(1);
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < NE; i++)
                cfg_write(s, i, t_addr[s][i], t_mask[s][i], t_data[s][i]);

        // Run A: set 0, immediate DRDY, first two writes hand-computed
        resp_delay = 0;
        push_run(0, 1'b1, 1'b1, 0);
        start(0);
        chk("a_busy_after_sen", BUSY, 1);
        chk("a_pll_rst_after_sen", PLL_RST, 1);
        wait_srdy(2000, n);
        tick(1);
        chk("a_srdy_one_cycle", SRDY, 0);
        chk("a_busy_dropped", BUSY, 0);

        // Run B: set 1, DRDY delay 1, SEN and CFG_WE while busy must be ignored
        resp_delay = 1;
        push_run(1, 1'b1, 1'b0, 0);
        start(1);
        tick(30);
        chk("b_busy_mid", BUSY, 1);
        SEN = 1'b1;
        SSEL = 1'b0;
        cfg_write(0, 0, 7'h7F, 16'h0000, 16'hFFFF);
        SEN = 1'b0;
        cfg_write(1, 5, 7'h7E, 16'h0000, 16'h5555);
        wait_srdy(2000, n);
        extra = 0;
        repeat (10) begin
            @(negedge DCLK);
            if (SRDY !== 1'b0 || BUSY !== 1'b0) extra++;
        end
        chk("b_sen_not_queued", extra, 0);

        // Run C: set 0 again with DRDY delay 10; table must be unchanged
        resp_delay = 10;
        push_run(0, 1'b1, 1'b0, 0);
        start(0);
        wait_srdy(4000, n);
        tick(2);

        // DRDY never returns: SRDY comes DRDY_TO cycles after the first DEN
        resp_delay = 0;
        mute = 1;
        push_run(0, 1'b0, 1'b0, 1);
        start(0);
        tick(1);
        chk("to_first_den", DEN, 1);
        wait_srdy(200, n);
        chk("to_cycles_den_to_srdy", n, DRDY_TO);
        tick(1);
        chk("to_err_sticky", ERR, 1);
        chk("to_busy_dropped", BUSY, 0);
        mute = 0;
        tick(1);
        push_run(1, 1'b1, 1'b0, 0);
        start(1);
        chk("to_err_cleared", ERR, 0);
        wait_srdy(2000, n);
        tick(2);

        // Reset asserted during RD_WAIT, then a fresh run from entry 0
        mute = 1;
        push_run(0, 1'b0, 1'b0, -1);
        start(0);
        tick(1);
        chk("ra_den_rd", DEN, 1);
        tick(1);
        RST_N = 1'b0;
        tick(1);
        chk("ra_den", DEN, 0);
        chk("ra_pll_rst", PLL_RST, 0);
        chk("ra_busy", BUSY, 0);
        RST_N = 1'b1;
        mute = 0;
        tick(1);
        push_run(0, 1'b1, 1'b0, 0);
        start(0);
        wait_srdy(2000, n);
        tick(2);

        // LOCKED never rises: FAIL LOCK_TO cycles after PLL_RST release
        lock_delay = -1;
        push_run(1, 1'b1, 1'b0, 1);
        start(1);
        n = 0;
        while (PLL_RST !== 1'b0 && n < 2000) begin
            @(negedge DCLK);
            n++;
        end
        chk("lt_pll_rst_released", PLL_RST, 0);
        wait_srdy(300, n);
        chk("lt_cycles_release_to_srdy", n, LOCK_TO);
        tick(2);

        // LOCKED rises 20 cycles after release: SRDY follows one cycle later
        lock_delay = 20;
        push_run(0, 1'b1, 1'b0, 0);
        start(0);
        n = 0;
        while (LOCKED !== 1'b1 && n < 2000) begin
            @(negedge DCLK);
            #1;
            n++;
        end
        chk("lk_locked_seen", LOCKED, 1);
        wait_srdy(50, n);
        chk("lk_cycles_locked_to_srdy", n, 1);
        tick(5);

        chk("drp_queue_drained", exp_q.size(), 0);
        chk("srdy_queue_drained", exp_err_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
